// File: rtl/sim_step_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_pkg
// Brief    : Shared types and constants for the fluid-sim frame scheduler.
// Revision : 1.0
// ============================================================================
package sim_pkg;

    localparam int c_MAX_ITERS = 16;
    localparam int c_TIMEOUT   = 65535;

    typedef enum logic [2:0] {
        SCHED_IDLE       = 3'd0,
        SCHED_PROJ_START = 3'd1,
        SCHED_PROJ_WAIT  = 3'd2,
        SCHED_ADV_START  = 3'd3,
        SCHED_ADV_WAIT   = 3'd4,
        SCHED_SWAP       = 3'd5
    } sched_state_e;

    typedef struct packed {
        logic [31:0] xn;
        logic [31:0] yn;
        logic [31:0] mag;
    } field_word_t;

endpackage
`default_nettype wire

// File: rtl/sim_step_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sim_step_scheduler_if
// Brief    : Start/done handshakes and field write port between scheduler and datapaths.
// Revision : 1.0
// ============================================================================
interface sim_step_scheduler_if #(
    parameter int FIELD_ADDRW = 6,
    parameter int FIELD_DATAW = 96
);
    logic                   proj_start;
    logic                   proj_done;
    logic                   adv_start;
    logic                   adv_done;
    logic [FIELD_ADDRW-1:0] f_addr_in;
    logic [FIELD_DATAW-1:0] f_data_in;
    logic                   f_we_in;
    logic [FIELD_ADDRW:0]   f_addr_out;
    logic [FIELD_DATAW-1:0] f_data_out;
    logic                   f_we_out;

    modport master (
        output proj_start, adv_start, f_addr_out, f_data_out, f_we_out,
        input  proj_done, adv_done, f_addr_in, f_data_in, f_we_in
    );

    modport slave (
        input  proj_start, adv_start, f_addr_out, f_data_out, f_we_out,
        output proj_done, adv_done, f_addr_in, f_data_in, f_we_in
    );
endinterface
`default_nettype wire

// File: rtl/sim_step_scheduler_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : sched_watchdog
// Brief    : Loadable down-counter flagging a phase that waited too long for done.
// Revision : 1.0
// ============================================================================
module sched_watchdog #(
    parameter int TIMEOUT = 65535,
    parameter int TOW     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);
    logic [TOW-1:0] r_cnt;

    assign o_expired = i_run && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= TOW'(TIMEOUT);
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sim_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sim_step_scheduler
// Brief    : Per-frame sequencer: N projection passes, one advect pass, bank swap.
// Revision : 1.0
// ============================================================================
module sim_step_scheduler
    import sim_pkg::*;
#(
    parameter int FIELD_ADDRW = 6,
    parameter int FIELD_DATAW = 96,
    parameter int MAX_ITERS   = c_MAX_ITERS,
    parameter int ITERW       = 5,
    parameter int TIMEOUT     = c_TIMEOUT,
    parameter int TOW         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_frame_start,
    input  logic [ITERW-1:0] i_iters_cfg,
    sim_step_scheduler_if.master bus,
    output logic             o_disp_bank,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_err_timeout,
    output logic [15:0]      o_overrun_cnt
);
    localparam logic [2:0] c_ST_IDLE       = SCHED_IDLE;
    localparam logic [2:0] c_ST_PROJ_START = SCHED_PROJ_START;
    localparam logic [2:0] c_ST_PROJ_WAIT  = SCHED_PROJ_WAIT;
    localparam logic [2:0] c_ST_ADV_START  = SCHED_ADV_START;
    localparam logic [2:0] c_ST_ADV_WAIT   = SCHED_ADV_WAIT;
    localparam logic [2:0] c_ST_SWAP       = SCHED_SWAP;

    logic [2:0]             r_state;
    logic                   r_back_bank;
    logic                   r_pending;
    logic                   r_proj_start;
    logic                   r_adv_start;
    logic                   r_err;
    logic [15:0]            r_overrun;
    logic [ITERW-1:0]       r_iters;
    logic [ITERW-1:0]       r_iter_cnt;
    logic [ITERW-1:0]       w_iter_next;
    logic [ITERW-1:0]       w_iters_clamped;
    logic                   w_busy;
    logic                   w_start;
    logic                   w_wd_load;
    logic                   w_wd_run;
    logic                   w_expired;
    logic [FIELD_ADDRW-1:0] w_addr;
    logic [FIELD_DATAW-1:0] w_data;

    assign w_busy          = (r_state != c_ST_IDLE);
    assign w_start         = (r_state == c_ST_IDLE) && i_enable && (i_frame_start || r_pending);
    assign w_iters_clamped = (i_iters_cfg > ITERW'(MAX_ITERS)) ? ITERW'(MAX_ITERS) : i_iters_cfg;
    assign w_iter_next     = r_iter_cnt + 1'b1;
    assign w_wd_load       = (r_state == c_ST_PROJ_START) || (r_state == c_ST_ADV_START);
    assign w_wd_run        = (r_state == c_ST_PROJ_WAIT) || (r_state == c_ST_ADV_WAIT);

    sched_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_wd_load),
        .i_run     (w_wd_run),
        .o_expired (w_expired)
    );

    // Writes land in the back bank; the bank only flips in SWAP, so it is stable during projection.
    assign w_addr         = bus.f_addr_in;
    assign w_data         = bus.f_data_in;
    assign bus.f_addr_out = {r_back_bank, w_addr};
    assign bus.f_data_out = w_data;
    assign bus.f_we_out   = bus.f_we_in && (r_state == c_ST_PROJ_WAIT);
    assign bus.proj_start = r_proj_start;
    assign bus.adv_start  = r_adv_start;

    assign o_disp_bank   = ~r_back_bank;
    assign o_busy        = w_busy;
    assign o_frame_done  = (r_state == c_ST_SWAP);
    assign o_err_timeout = r_err;
    assign o_overrun_cnt = r_overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_back_bank  <= 1'b1;
            r_pending    <= 1'b0;
            r_proj_start <= 1'b0;
            r_adv_start  <= 1'b0;
            r_err        <= 1'b0;
            r_overrun    <= '0;
            r_iters      <= '0;
            r_iter_cnt   <= '0;
        end else begin
            r_proj_start <= (r_state == c_ST_PROJ_START);
            r_adv_start  <= (r_state == c_ST_ADV_START);

            // One tick may queue behind a running frame; further ticks are counted as dropped.
            if (w_busy && i_frame_start) begin
                if (!r_pending) begin
                    r_pending <= 1'b1;
                end else if (r_overrun != 16'hFFFF) begin
                    r_overrun <= r_overrun + 16'd1;
                end
            end else if (w_start) begin
                r_pending <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_iters    <= w_iters_clamped;
                        r_iter_cnt <= '0;
                        r_state    <= (w_iters_clamped == '0) ? c_ST_ADV_START : c_ST_PROJ_START;
                    end
                end
                c_ST_PROJ_START: r_state <= c_ST_PROJ_WAIT;
                c_ST_PROJ_WAIT: begin
                    if (bus.proj_done) begin
                        r_iter_cnt <= w_iter_next;
                        r_state    <= (w_iter_next == r_iters) ? c_ST_ADV_START : c_ST_PROJ_START;
                    end else if (w_expired) begin
                        r_err      <= 1'b1;
                        r_iter_cnt <= '0;
                        r_state    <= c_ST_IDLE;
                    end
                end
                c_ST_ADV_START: r_state <= c_ST_ADV_WAIT;
                c_ST_ADV_WAIT: begin
                    if (bus.adv_done) begin
                        r_state <= c_ST_SWAP;
                    end else if (w_expired) begin
                        r_err      <= 1'b1;
                        r_iter_cnt <= '0;
                        r_state    <= c_ST_IDLE;
                    end
                end
                c_ST_SWAP: begin
                    r_back_bank <= ~r_back_bank;
                    r_state     <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sim_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_step_scheduler
// Brief    : Self-checking bench for the frame scheduler with a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_sim_step_scheduler;
    localparam int TB_TIMEOUT = 300;
    localparam int TB_MAXIT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_start;
    logic [4:0]  iters_cfg;
    logic        disp_bank;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;
    logic [15:0] overrun_cnt;

    int checks   = 0;
    int failures = 0;
    int n_proj   = 0;
    int n_adv    = 0;
    int reply_delay = 5;
    bit auto_reply  = 1'b1;

    bit exp_disp    = 1'b0;
    bit exp_err     = 1'b0;
    int exp_overrun = 0;

    always #5 clk = ~clk;

    sim_step_scheduler_if #(.FIELD_ADDRW(6), .FIELD_DATAW(96)) bus ();

    sim_step_scheduler #(
        .FIELD_ADDRW (6),
        .FIELD_DATAW (96),
        .MAX_ITERS   (TB_MAXIT),
        .ITERW       (5),
        .TIMEOUT     (TB_TIMEOUT),
        .TOW         (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (enable),
        .i_frame_start (frame_start),
        .i_iters_cfg   (iters_cfg),
        .bus           (bus),
        .o_disp_bank   (disp_bank),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_err_timeout (err_timeout),
        .o_overrun_cnt (overrun_cnt)
    );

    always @(negedge clk) begin
        if (bus.proj_start) n_proj++;
        if (bus.adv_start)  n_adv++;
    end

    // Datapath stand-in: answers each start with a done pulse reply_delay cycles later.
    initial begin
        bit is_proj;
        bus.proj_done = 1'b0;
        bus.adv_done  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (auto_reply && (bus.proj_start || bus.adv_start)) begin
                is_proj = bus.proj_start;
                repeat (reply_delay) @(posedge clk);
                #1;
                if (is_proj) bus.proj_done = 1'b1;
                else         bus.adv_done  = 1'b1;
                @(posedge clk); #1;
                bus.proj_done = 1'b0;
                bus.adv_done  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input int cfg, input int dly, input string name);
        int  p0, a0, exp_p;
        bit  ok;
        exp_p = (cfg > TB_MAXIT) ? TB_MAXIT : cfg;
        iters_cfg   = 5'(cfg);
        reply_delay = dly;
        p0 = n_proj;
        a0 = n_adv;
        tick();
        iters_cfg = 5'($urandom_range(0, 31));
        wait_done((exp_p + 1) * (dly + 6) + 30, ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s frame_done: got none, required a pulse", name);
        end
        exp_disp = ~exp_disp;
        @(negedge clk);
        checks++;
        if ((n_proj - p0) !== exp_p) begin
            failures++;
            $display("FAIL %s proj_count: got %0d required %0d", name, n_proj - p0, exp_p);
        end
        checks++;
        if ((n_adv - a0) !== 1) begin
            failures++;
            $display("FAIL %s adv_count: got %0d required 1", name, n_adv - a0);
        end
        checks++;
        if (disp_bank !== exp_disp || busy !== 1'b0 || err_timeout !== exp_err) begin
            failures++;
            $display("FAIL %s post_frame: disp=%b busy=%b err=%b required disp=%b busy=0 err=%b",
                     name, disp_bank, busy, err_timeout, exp_disp, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; frame_start = 1'b0; iters_cfg = '0;
        bus.f_addr_in = '0; bus.f_data_in = '0; bus.f_we_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.proj_start !== 1'b0 || bus.adv_start !== 1'b0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || err_timeout !== 1'b0 || overrun_cnt !== 16'd0 ||
            disp_bank !== 1'b0 || bus.f_we_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ps=%b as=%b busy=%b fd=%b err=%b ovr=%0d disp=%b we=%b required all 0",
                     bus.proj_start, bus.adv_start, busy, frame_done, err_timeout, overrun_cnt,
                     disp_bank, bus.f_we_out);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_three_iters();
        run_frame(3, 10, "t1_iters3");
    endtask

    task automatic test_zero_iters();
        int  p0;
        bit  ok;
        iters_cfg = 5'd0;
        reply_delay = 4;
        p0 = n_proj;
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.adv_start !== 1'b0) begin
            failures++;
            $display("FAIL t2_adv_early: adv_start=%b at t+1 required 0", bus.adv_start);
        end
        @(negedge clk);
        checks++;
        if (bus.adv_start !== 1'b1) begin
            failures++;
            $display("FAIL t2_adv_latency: adv_start=%b at t+2 required 1", bus.adv_start);
        end
        wait_done(40, ok);
        exp_disp = ~exp_disp;
        @(negedge clk);
        checks++;
        if (ok !== 1'b1 || n_proj !== p0 || disp_bank !== exp_disp) begin
            failures++;
            $display("FAIL t2_zero_iters: done=%b proj=%0d disp=%b required done=1 proj=0 disp=%b",
                     ok, n_proj - p0, disp_bank, exp_disp);
        end
    endtask

    task automatic test_clamp();
        run_frame(20, 2, "t3_clamp");
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 6; k++) begin
            run_frame(int'($urandom_range(0, 20)), int'($urandom_range(1, 5)), "rand_frame");
        end
    endtask

    task automatic test_pending();
        int  p0;
        bit  ok;
        bit  seen;
        iters_cfg = 5'd2;
        reply_delay = 10;
        p0 = n_proj;
        tick();
        repeat (3) @(posedge clk);
        tick();
        tick();
        exp_overrun = exp_overrun + 1;
        @(negedge clk);
        checks++;
        if (overrun_cnt !== 16'(exp_overrun)) begin
            failures++;
            $display("FAIL t4_overrun: got %0d required %0d", overrun_cnt, exp_overrun);
        end
        wait_done(100, ok);
        exp_disp = ~exp_disp;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.proj_start) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (ok !== 1'b1 || seen !== 1'b1) begin
            failures++;
            $display("FAIL t4_pending_restart: done=%b restart=%b required 1 1", ok, seen);
        end
        wait_done(100, ok);
        exp_disp = ~exp_disp;
        repeat (10) @(negedge clk);
        checks++;
        if (ok !== 1'b1 || (n_proj - p0) !== 4 || busy !== 1'b0 || disp_bank !== exp_disp) begin
            failures++;
            $display("FAIL t4_second_frame: done=%b proj=%0d busy=%b disp=%b required 1 4 0 %b",
                     ok, n_proj - p0, busy, disp_bank, exp_disp);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        auto_reply = 1'b0;
        iters_cfg = 5'd1;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.proj_start) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (TB_TIMEOUT - 10) @(negedge clk);
        checks++;
        if (seen !== 1'b1 || err_timeout !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t5_before_expiry: start=%b err=%b busy=%b required 1 0 1",
                     seen, err_timeout, busy);
        end
        repeat (20) @(negedge clk);
        exp_err = 1'b1;
        checks++;
        if (err_timeout !== exp_err || busy !== 1'b0 || disp_bank !== exp_disp) begin
            failures++;
            $display("FAIL t5_expired: err=%b busy=%b disp=%b required 1 0 %b",
                     err_timeout, busy, disp_bank, exp_disp);
        end
        auto_reply = 1'b1;
        run_frame(2, 3, "t5_recover");
    endtask

    task automatic test_reset_midframe();
        bit          seen;
        logic [5:0]  addr;
        logic [95:0] data;
        auto_reply = 1'b0;
        iters_cfg = 5'd2;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.proj_start) begin
                seen = 1'b1;
                break;
            end
        end
        addr = 6'($urandom);
        data = {$urandom, $urandom, $urandom};
        bus.f_addr_in = addr;
        bus.f_data_in = data;
        bus.f_we_in   = 1'b1;
        #1;
        checks++;
        if (seen !== 1'b1 || bus.f_we_out !== 1'b1 || bus.f_addr_out !== {~exp_disp, addr} ||
            bus.f_data_out !== data) begin
            failures++;
            $display("FAIL t6_write_route: start=%b we=%b addr=%h data=%h required 1 1 %h %h",
                     seen, bus.f_we_out, bus.f_addr_out, bus.f_data_out, {~exp_disp, addr}, data);
        end
        #1 rst = 1'b1;
        #1;
        exp_disp = 1'b0; exp_err = 1'b0; exp_overrun = 0;
        checks++;
        if (bus.proj_start !== 1'b0 || bus.adv_start !== 1'b0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || err_timeout !== 1'b0 || overrun_cnt !== 16'd0 ||
            disp_bank !== exp_disp || bus.f_we_out !== 1'b0) begin
            failures++;
            $display("FAIL t6_async_reset: busy=%b err=%b ovr=%0d disp=%b we=%b required all 0",
                     busy, err_timeout, overrun_cnt, disp_bank, bus.f_we_out);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.f_we_out !== 1'b0) begin
            failures++;
            $display("FAIL t6_we_gate_idle: f_we_out=%b required 0", bus.f_we_out);
        end
        bus.f_we_in = 1'b0;
        auto_reply = 1'b1;
        run_frame(1, 4, "t6_after_reset");
    endtask

    initial begin
        test_reset();
        test_three_iters();
        test_zero_iters();
        test_clamp();
        test_random_frames();
        test_pending();
        test_timeout();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
